// File: rtl/board_reset_sequencer.sv
// board_reset_sequencer: nPOR-driven board bring-up (global, staggered channel, calibration, kernel reset) with status LEDs; optional heartbeat LED via BOARD_RESET_HEARTBEAT_EN
module board_reset_sequencer #(
   parameter int                      NUM_CHANNELS   = 6,
   parameter logic [NUM_CHANNELS-1:0] CHAN_MASK      = '1,
   parameter int                      POR_CYCLES     = 1024,
   parameter int                      STAGGER_CYCLES = 64,
   parameter int                      CAL_TIMEOUT    = 1 << 20,
   parameter int                      MAX_RETRY      = 3,
   parameter int                      KERNEL_HOLD    = 256,
   parameter int                      LED_WIDTH      = 8,
   parameter int                      HEARTBEAT_BITS = 25
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic                    pcie_npor,
   input  logic [NUM_CHANNELS-1:0] cal_success,
   input  logic [NUM_CHANNELS-1:0] cal_fail,
   output logic                    global_reset_n,
   output logic [NUM_CHANNELS-1:0] chan_reset_n,
   output logic                    kernel_reset_n,
   output logic                    ready,
   output logic                    error,
   output logic [2:0]              seq_state,
   output logic [3:0]              retry_cnt,
   output logic [LED_WIDTH-1:0]    leds
);
   typedef enum logic [2:0] {
      S_POR    = 3'd0,
      S_MEM    = 3'd1,
      S_CAL    = 3'd2,
      S_KERNEL = 3'd3,
      S_RUN    = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   // one shared counter, cleared on every state entry, sized for the longest limit
   localparam int L1 = POR_CYCLES > STAGGER_CYCLES ? POR_CYCLES : STAGGER_CYCLES;
   localparam int L2 = CAL_TIMEOUT > KERNEL_HOLD ? CAL_TIMEOUT : KERNEL_HOLD;
   localparam int MAX_LIM = L1 > L2 ? L1 : L2;
   localparam int CW = MAX_LIM > 1 ? $clog2(MAX_LIM) : 1;
   localparam logic [CW-1:0] POR_END = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] STG_END = CW'(STAGGER_CYCLES - 1);
   localparam logic [CW-1:0] CAL_END = CW'(CAL_TIMEOUT - 1);
   localparam logic [CW-1:0] KH_END  = CW'(KERNEL_HOLD - 1);
   localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

   state_t                  r_state, w_state_nx;
   logic [CW-1:0]           r_cnt, w_cnt_nx;
   logic [NUM_CHANNELS-1:0] r_chan, w_chan_nx, r_led_cal, w_pending, w_first;
   logic [3:0]              r_retry, w_retry_nx;
   logic                    r_npor_meta, r_npor_s, r_global_n, r_run, r_error;
   logic                    w_fail, w_pass, w_lost, w_led_top;

   // channels still waiting for release, and the lowest-index one among them
   assign w_pending = CHAN_MASK & ~r_chan;
   assign w_first   = w_pending & (~w_pending + NUM_CHANNELS'(1));
   assign w_pass    = (cal_success & CHAN_MASK) == CHAN_MASK;
   assign w_fail    = (|(cal_fail & CHAN_MASK)) || (r_cnt == CAL_END);
   assign w_lost    = !w_pass || (|(cal_fail & CHAN_MASK));

   // next-state, counter, channel-release and retry logic; nPOR overrides everything
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + CW'(1);
      w_chan_nx  = r_chan;
      w_retry_nx = r_retry;
      case (r_state)
         S_POR: begin
            if (r_cnt == POR_END) begin
               w_state_nx = (CHAN_MASK == '0) ? S_KERNEL : S_MEM;
               w_cnt_nx   = '0;
            end
         end
         S_MEM: begin
            if (w_pending == '0) begin
               w_state_nx = (CHAN_MASK == '0) ? S_KERNEL : S_CAL;
               w_cnt_nx   = '0;
            end else if (r_cnt == STG_END) begin
               w_chan_nx = r_chan | w_first;
               w_cnt_nx  = '0;
            end
         end
         S_CAL: begin
            if (w_fail) begin
               w_cnt_nx = '0;
               if (r_retry < RETRY_MAX) begin
                  w_retry_nx = r_retry + 4'd1;
                  w_chan_nx  = '0;
                  w_state_nx = S_MEM;
               end else begin
                  w_state_nx = S_ERR;
               end
            end else if (w_pass) begin
               w_state_nx = S_KERNEL;
               w_cnt_nx   = '0;
            end
         end
         S_KERNEL: begin
            if (r_cnt == KH_END) begin
               w_state_nx = S_RUN;
               w_cnt_nx   = '0;
            end
         end
         S_RUN: begin
            w_cnt_nx   = '0;
            w_state_nx = w_lost ? S_ERR : S_RUN;
         end
         S_ERR: w_cnt_nx = '0;
         default: begin
            w_state_nx = S_POR;
            w_cnt_nx   = '0;
            w_chan_nx  = '0;
         end
      endcase
      if (w_state_nx == S_ERR) w_chan_nx = '0;
      if (!r_npor_s) begin
         w_state_nx = S_POR;
         w_cnt_nx   = '0;
         w_chan_nx  = '0;
         w_retry_nx = '0;
      end
   end

   // state, counters, nPOR synchroniser and registered outputs
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         r_npor_meta <= 1'b0;
         r_npor_s    <= 1'b0;
         r_state     <= S_POR;
         r_cnt       <= '0;
         r_chan      <= '0;
         r_retry     <= '0;
         r_global_n  <= 1'b0;
         r_run       <= 1'b0;
         r_error     <= 1'b0;
         r_led_cal   <= '0;
      end else begin
         r_npor_meta <= pcie_npor;
         r_npor_s    <= r_npor_meta;
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_chan      <= w_chan_nx;
         r_retry     <= w_retry_nx;
         r_global_n  <= w_state_nx != S_POR;
         r_run       <= w_state_nx == S_RUN;
         r_error     <= w_state_nx == S_ERR;
         r_led_cal   <= cal_success & CHAN_MASK;
      end
   end

`ifdef BOARD_RESET_HEARTBEAT_EN
   logic [HEARTBEAT_BITS-1:0] r_hb;

   // free-running heartbeat divider: slow blink in RUN, fast blink in ERROR
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) r_hb <= '0;
      else r_hb <= r_hb + HEARTBEAT_BITS'(1);
   end

   assign w_led_top = r_run ? r_hb[HEARTBEAT_BITS-1] : ((r_state == S_ERR) ? r_hb[HEARTBEAT_BITS-3] : 1'b0);
`else
   assign w_led_top = r_run;
`endif

   // LED map: per-channel calibration, error, ready/heartbeat; unused bits 0
   always_comb begin
      leds                     = '0;
      leds[NUM_CHANNELS-1:0]   = r_led_cal;
      leds[LED_WIDTH-2]        = r_error;
      leds[LED_WIDTH-1]        = w_led_top;
   end

   assign global_reset_n = r_global_n;
   assign chan_reset_n   = r_chan;
   assign kernel_reset_n = r_run;
   assign ready          = r_run;
   assign error          = r_error;
   assign seq_state      = r_state;
   assign retry_cnt      = r_retry;
endmodule

// File: tb/tb_board_reset_sequencer.sv
// tb_board_reset_sequencer: directed bring-up, masking, retry, timeout, nPOR and calibration-loss scenarios
module tb_board_reset_sequencer;
   logic       clk = 1'b0, rst_n = 1'b0, npor = 1'b1, rst_b = 1'b0;
   logic [5:0] cs = '0, cf = '0, cs_b = '0, cf_b = '0;
   logic       g_n, k_n, rdy, err, g_n_b, k_n_b, rdy_b, err_b;
   logic [5:0] ch_n, ch_n_b;
   logic [2:0] st, st_b;
   logic [3:0] rc, rc_b;
   logic [7:0] leds, leds_b;
   logic [7:0] lm;
   logic       v;
   int         checks = 0, errors = 0;

`ifdef BOARD_RESET_HEARTBEAT_EN
   assign lm = 8'h7F;
`else
   assign lm = 8'hFF;
`endif

   always #5 clk = ~clk;

   board_reset_sequencer #(
      .NUM_CHANNELS(6), .CHAN_MASK(6'b111111), .POR_CYCLES(16), .STAGGER_CYCLES(4),
      .CAL_TIMEOUT(32), .MAX_RETRY(2), .KERNEL_HOLD(8), .LED_WIDTH(8), .HEARTBEAT_BITS(4)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .pcie_npor(npor), .cal_success(cs), .cal_fail(cf),
      .global_reset_n(g_n), .chan_reset_n(ch_n), .kernel_reset_n(k_n), .ready(rdy), .error(err),
      .seq_state(st), .retry_cnt(rc), .leds(leds)
   );

   board_reset_sequencer #(
      .NUM_CHANNELS(6), .CHAN_MASK(6'b000101), .POR_CYCLES(16), .STAGGER_CYCLES(4),
      .CAL_TIMEOUT(32), .MAX_RETRY(2), .KERNEL_HOLD(8), .LED_WIDTH(8), .HEARTBEAT_BITS(4)
   ) dut_m (
      .clk_clk(clk), .reset_reset_n(rst_b), .pcie_npor(1'b1), .cal_success(cs_b), .cal_fail(cf_b),
      .global_reset_n(g_n_b), .chan_reset_n(ch_n_b), .kernel_reset_n(k_n_b), .ready(rdy_b), .error(err_b),
      .seq_state(st_b), .retry_cnt(rc_b), .leds(leds_b)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_npor();
      npor = 1'b0;
      step(1);
      npor = 1'b1;
   endtask

   task automatic test_reset();
      step(3);
      checks++; if (st !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", st); end
      checks++; if ({g_n, ch_n, k_n, rdy, err} !== 10'd0) begin errors++; $display("FAIL rst_outputs got %b exp 0", {g_n, ch_n, k_n, rdy, err}); end
      checks++; if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds got %h exp 00", leds); end
      checks++; if (rc !== 4'd0) begin errors++; $display("FAIL rst_retry got %0d exp 0", rc); end
   endtask

   task automatic test_nominal();
      rst_n = 1'b1;
      step(17);
      checks++; if (g_n !== 1'b0 || st !== 3'd0) begin errors++; $display("FAIL nom_por_hold got g=%b st=%0d exp g=0 st=0", g_n, st); end
      step(1);
      checks++; if (g_n !== 1'b1 || st !== 3'd1 || ch_n !== 6'h00) begin errors++; $display("FAIL nom_global_rel got g=%b st=%0d ch=%h exp 1 1 00", g_n, st, ch_n); end
      step(4);
      checks++; if (ch_n !== 6'h01) begin errors++; $display("FAIL nom_ch0 got %h exp 01", ch_n); end
      step(3);
      checks++; if (ch_n !== 6'h01) begin errors++; $display("FAIL nom_ch1_early got %h exp 01", ch_n); end
      step(1);
      checks++; if (ch_n !== 6'h03) begin errors++; $display("FAIL nom_ch1 got %h exp 03", ch_n); end
      step(16);
      checks++; if (ch_n !== 6'h3F || st !== 3'd1) begin errors++; $display("FAIL nom_all_rel got ch=%h st=%0d exp 3f 1", ch_n, st); end
      step(1);
      checks++; if (st !== 3'd2 || k_n !== 1'b0) begin errors++; $display("FAIL nom_cal_entry got st=%0d k=%b exp 2 0", st, k_n); end
      step(8);
      cs = 6'h3F;
      step(1);
      checks++; if (st !== 3'd3) begin errors++; $display("FAIL nom_kernel_entry got %0d exp 3", st); end
      step(7);
      checks++; if (st !== 3'd3 || k_n !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL nom_kernel_hold got st=%0d k=%b r=%b exp 3 0 0", st, k_n, rdy); end
      step(1);
      checks++; if (st !== 3'd4 || k_n !== 1'b1 || rdy !== 1'b1 || g_n !== 1'b1) begin errors++; $display("FAIL nom_run got st=%0d k=%b r=%b g=%b exp 4 1 1 1", st, k_n, rdy, g_n); end
      checks++; if ((leds & lm) !== (8'hBF & lm) || rc !== 4'd0) begin errors++; $display("FAIL nom_leds got %h rc=%0d exp bf 0", leds, rc); end
`ifdef BOARD_RESET_HEARTBEAT_EN
      v = leds[7];
      step(8);
      checks++; if (leds[7] !== ~v) begin errors++; $display("FAIL nom_hb_run got %b exp %b", leds[7], ~v); end
`endif
   endtask

   task automatic test_cal_loss();
      cs = 6'h3D;
      step(1);
      checks++; if (st !== 3'd5 || err !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL loss_error got st=%0d e=%b r=%b exp 5 1 0", st, err, rdy); end
      checks++; if (k_n !== 1'b0 || ch_n !== 6'h00 || g_n !== 1'b1) begin errors++; $display("FAIL loss_resets got k=%b ch=%h g=%b exp 0 00 1", k_n, ch_n, g_n); end
      checks++; if ((leds & lm) !== (8'h7D & lm)) begin errors++; $display("FAIL loss_leds got %h exp 7d", leds); end
`ifdef BOARD_RESET_HEARTBEAT_EN
      v = leds[7];
      step(2);
      checks++; if (leds[7] !== ~v) begin errors++; $display("FAIL loss_hb_err got %b exp %b", leds[7], ~v); end
`endif
      cs = 6'h3F;
      step(10);
      checks++; if (st !== 3'd5 || err !== 1'b1) begin errors++; $display("FAIL loss_sticky got st=%0d e=%b exp 5 1", st, err); end
   endtask

   task automatic test_npor_error();
      pulse_npor();
      step(1);
      checks++; if (st !== 3'd5) begin errors++; $display("FAIL nerr_sync_lat got %0d exp 5", st); end
      step(1);
      checks++; if (st !== 3'd0 || {g_n, ch_n, k_n, err, rdy} !== 10'd0 || rc !== 4'd0) begin errors++; $display("FAIL nerr_por got st=%0d outs=%b rc=%0d exp 0 0 0", st, {g_n, ch_n, k_n, err, rdy}, rc); end
      step(15);
      checks++; if (g_n !== 1'b0) begin errors++; $display("FAIL nerr_por_hold got %b exp 0", g_n); end
      step(1);
      checks++; if (g_n !== 1'b1 || st !== 3'd1) begin errors++; $display("FAIL nerr_global got g=%b st=%0d exp 1 1", g_n, st); end
      step(24);
      checks++; if (ch_n !== 6'h3F) begin errors++; $display("FAIL nerr_chan got %h exp 3f", ch_n); end
      step(2);
      checks++; if (st !== 3'd3) begin errors++; $display("FAIL nerr_kernel got %0d exp 3", st); end
      step(8);
      checks++; if (st !== 3'd4 || rdy !== 1'b1) begin errors++; $display("FAIL nerr_run got st=%0d r=%b exp 4 1", st, rdy); end
   endtask

   task automatic test_npor_run();
      pulse_npor();
      step(1);
      checks++; if (st !== 3'd4) begin errors++; $display("FAIL nrun_sync_lat got %0d exp 4", st); end
      step(1);
      checks++; if (st !== 3'd0 || {g_n, ch_n, k_n, rdy} !== 9'd0 || rc !== 4'd0) begin errors++; $display("FAIL nrun_por got st=%0d outs=%b rc=%0d exp 0 0 0", st, {g_n, ch_n, k_n, rdy}, rc); end
      cs = 6'h00;
   endtask

   task automatic test_retry();
      step(41);
      checks++; if (st !== 3'd2) begin errors++; $display("FAIL retry_cal1 got %0d exp 2", st); end
      step(2);
      checks++; if (ch_n !== 6'h3F) begin errors++; $display("FAIL retry_pre_fail got %h exp 3f", ch_n); end
      cf = 6'h08;
      step(1);
      cf = 6'h00;
      checks++; if (st !== 3'd1 || rc !== 4'd1 || ch_n !== 6'h00) begin errors++; $display("FAIL retry_fail1 got st=%0d rc=%0d ch=%h exp 1 1 00", st, rc, ch_n); end
      step(25);
      checks++; if (st !== 3'd2 || ch_n !== 6'h3F) begin errors++; $display("FAIL retry_cal2 got st=%0d ch=%h exp 2 3f", st, ch_n); end
      step(1);
      cs = 6'h3F;
      cf = 6'h09;
      step(1);
      cf = 6'h00;
      checks++; if (st !== 3'd1 || rc !== 4'd2 || ch_n !== 6'h00) begin errors++; $display("FAIL retry_fail_wins got st=%0d rc=%0d ch=%h exp 1 2 00", st, rc, ch_n); end
      step(25);
      checks++; if (st !== 3'd2) begin errors++; $display("FAIL retry_cal3 got %0d exp 2", st); end
      step(1);
      checks++; if (st !== 3'd3) begin errors++; $display("FAIL retry_pass got %0d exp 3", st); end
      step(8);
      checks++; if (st !== 3'd4 || rc !== 4'd2 || rdy !== 1'b1) begin errors++; $display("FAIL retry_run got st=%0d rc=%0d r=%b exp 4 2 1", st, rc, rdy); end
   endtask

   task automatic test_timeout();
      pulse_npor();
      step(2);
      checks++; if (st !== 3'd0 || rc !== 4'd0) begin errors++; $display("FAIL tmo_por got st=%0d rc=%0d exp 0 0", st, rc); end
      cs = 6'h00;
      step(41);
      checks++; if (st !== 3'd2) begin errors++; $display("FAIL tmo_cal1 got %0d exp 2", st); end
      step(31);
      checks++; if (st !== 3'd2) begin errors++; $display("FAIL tmo_before1 got %0d exp 2", st); end
      step(1);
      checks++; if (st !== 3'd1 || rc !== 4'd1 || ch_n !== 6'h00) begin errors++; $display("FAIL tmo_1 got st=%0d rc=%0d ch=%h exp 1 1 00", st, rc, ch_n); end
      step(57);
      checks++; if (st !== 3'd1 || rc !== 4'd2) begin errors++; $display("FAIL tmo_2 got st=%0d rc=%0d exp 1 2", st, rc); end
      step(56);
      checks++; if (st !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL tmo_before3 got st=%0d e=%b exp 2 0", st, err); end
      step(1);
      checks++; if (st !== 3'd5 || err !== 1'b1 || k_n !== 1'b0 || rc !== 4'd2 || g_n !== 1'b1) begin errors++; $display("FAIL tmo_error got st=%0d e=%b k=%b rc=%0d g=%b exp 5 1 0 2 1", st, err, k_n, rc, g_n); end
      checks++; if ((leds & lm) !== (8'h40 & lm)) begin errors++; $display("FAIL tmo_leds got %h exp 40", leds); end
      step(20);
      cs = 6'h3F;
      step(5);
      checks++; if (st !== 3'd5 || err !== 1'b1 || ch_n !== 6'h00) begin errors++; $display("FAIL tmo_sticky got st=%0d e=%b ch=%h exp 5 1 00", st, err, ch_n); end
   endtask

   task automatic test_masked();
      cs_b = 6'b000101;
      rst_b = 1'b1;
      step(21);
      checks++; if (ch_n_b !== 6'h00 || st_b !== 3'd1) begin errors++; $display("FAIL mask_pre got ch=%h st=%0d exp 00 1", ch_n_b, st_b); end
      step(1);
      checks++; if (ch_n_b !== 6'h01) begin errors++; $display("FAIL mask_ch0 got %h exp 01", ch_n_b); end
      step(3);
      checks++; if (ch_n_b !== 6'h01) begin errors++; $display("FAIL mask_gap got %h exp 01", ch_n_b); end
      step(1);
      checks++; if (ch_n_b !== 6'h05) begin errors++; $display("FAIL mask_ch2 got %h exp 05", ch_n_b); end
      step(1);
      checks++; if (st_b !== 3'd2) begin errors++; $display("FAIL mask_cal got %0d exp 2", st_b); end
      step(1);
      checks++; if (st_b !== 3'd3) begin errors++; $display("FAIL mask_pass got %0d exp 3", st_b); end
      step(8);
      checks++; if (st_b !== 3'd4 || rdy_b !== 1'b1 || ch_n_b !== 6'h05) begin errors++; $display("FAIL mask_run got st=%0d r=%b ch=%h exp 4 1 05", st_b, rdy_b, ch_n_b); end
      checks++; if ((leds_b & lm) !== (8'h85 & lm)) begin errors++; $display("FAIL mask_leds got %h exp 85", leds_b); end
      cf_b = 6'b000010;
      step(3);
      checks++; if (st_b !== 3'd4 || err_b !== 1'b0) begin errors++; $display("FAIL mask_ignore_fail got st=%0d e=%b exp 4 0", st_b, err_b); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_cal_loss();
      test_npor_error();
      test_npor_run();
      test_retry();
      test_timeout();
      test_masked();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/board_reset_sequencer.md
Name: board_reset_sequencer

Overview:
Parametrised board-level reset and bring-up sequencer for the accelerator top level. It replaces the tied-high global reset and static LED pattern. It turns PCIe nPOR into an ordered sequence:
- global reset release
- staggered per-memory-channel reset release (DDR3/QDRII controllers)
- calibration wait with timeout and retry
- kernel reset release
- live LED status
It sits in the top level between the board pins and the system instance.

Parameters:
- NUM_CHANNELS, 6, number of memory channels sequenced (1..LED_WIDTH-2).
- CHAN_MASK, 6'b111111, per-channel enable; disabled channels are held in reset and ignored for calibration.
- POR_CYCLES, 1024, cycles global reset is held after nPOR/reset release (>=2).
- STAGGER_CYCLES, 64, spacing between successive channel reset releases (>=1).
- CAL_TIMEOUT, 2^20, max cycles in CAL_WAIT per attempt (>=2).
- MAX_RETRY, 3, calibration retries before ERROR (0..15).
- KERNEL_HOLD, 256, cycles kernel reset is held after calibration passes (>=1).
- LED_WIDTH, 8, LED vector width.
- HEARTBEAT_BITS, 25, heartbeat divider width (used only with the optional feature).

Ports:
- clk_clk, in, 1, config clock (50 MHz board oscillator).
- reset_reset_n, in, 1, synchronous active-low reset.
- pcie_npor, in, 1, asynchronous PCIe nPOR, active-low; synchronised internally.
- cal_success, in, NUM_CHANNELS, per-channel calibration success level, synchronous to clk_clk.
- cal_fail, in, NUM_CHANNELS, per-channel calibration fail level, synchronous to clk_clk.
- global_reset_n, out, 1, system global reset, active-low.
- chan_reset_n, out, NUM_CHANNELS, per-channel controller reset, active-low.
- kernel_reset_n, out, 1, kernel clock domain reset request, active-low.
- ready, out, 1, high only in RUN.
- error, out, 1, high only in ERROR.
- seq_state, out, 3, current state encoding.
- retry_cnt, out, 4, calibration attempts consumed.
- leds, out, LED_WIDTH, status LEDs, active-high.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-low on reset_reset_n. While reset_reset_n is low at a clk_clk edge:
  - state=POR, all counters 0, retry_cnt=0, 2-FF npor synchroniser cleared to 0.
  - global_reset_n=0, chan_reset_n=0, kernel_reset_n=0, ready=0, error=0, leds=0.
- nPOR: pcie_npor passes a 2-FF synchroniser (npor_s, 2-cycle latency). npor_s=0 in any state forces state POR next cycle, clears all counters and retry_cnt, and asserts all resets. It has priority over every other transition.
- States and seq_state encoding: POR=0, MEM_RST=1, CAL_WAIT=2, KERNEL_RST=3, RUN=4, ERROR=5. All outputs are registered.
- POR: counter counts while npor_s=1. When the count reaches POR_CYCLES-1, go to MEM_RST; global_reset_n=1 from that cycle on.
- MEM_RST:
  - Stagger counter counts 0..STAGGER_CYCLES-1. Each expiry releases the next enabled channel in ascending index order; disabled channels are skipped and stay 0.
  - After the last enabled channel is released, go to CAL_WAIT on the next cycle.
  - CHAN_MASK=0: go straight to KERNEL_RST.
- CAL_WAIT:
  - Timeout counter starts at 0 on entry.
  - Fail condition: any bit of (cal_fail & CHAN_MASK) set, or the counter reaches CAL_TIMEOUT-1.
  - On fail, fail wins over a simultaneous success:
    - retry_cnt < MAX_RETRY: retry_cnt+1, all chan_reset_n=0, go to MEM_RST (stagger restarts).
    - otherwise: go to ERROR.
  - Pass condition: (cal_success & CHAN_MASK)==CHAN_MASK with no fail; go to KERNEL_RST.
- KERNEL_RST: hold kernel_reset_n=0 for KERNEL_HOLD cycles, then go to RUN; kernel_reset_n=1 and ready=1 in the same cycle.
- RUN: any enabled cal_success falling to 0, or any enabled cal_fail going to 1, causes ERROR next cycle.
- ERROR:
  - Sticky; left only by reset_reset_n or npor_s=0.
  - kernel_reset_n=0, chan_reset_n=0, global_reset_n stays 1, error=1, ready=0.
- LEDs:
  - leds[i] = registered (cal_success[i] & CHAN_MASK[i]) for i<NUM_CHANNELS.
  - leds[LED_WIDTH-2] = error.
  - leds[LED_WIDTH-1] = ready.
  - Unused bits are 0.
- Widths: counters use $clog2 of their limit; all compares are unsigned. No counter ever wraps; every counter is cleared on state entry.

Optional Feature:
- Macro: BOARD_RESET_HEARTBEAT_EN.
- Defined: a free-running HEARTBEAT_BITS-bit counter runs whenever reset_reset_n=1. leds[LED_WIDTH-1] = ready ? counter MSB : (state==ERROR ? counter bit HEARTBEAT_BITS-3 : 0). This blinks in RUN and blinks fast in ERROR.
- Undefined: no counter is built; leds[LED_WIDTH-1] = ready.

Test Plan:
1. Nominal bring-up. Params NUM_CHANNELS=6, POR_CYCLES=16, STAGGER_CYCLES=4, KERNEL_HOLD=8; npor high; cal_success=6'h3F 10 cycles after the last release -> global_reset_n rises 18 cycles after npor (2 sync + 16), chan_reset_n releases at 4-cycle spacing, kernel_reset_n/ready rise 8 cycles after CAL_WAIT exit, leds=8'hBF.
2. Masked channels. CHAN_MASK=6'b000101 -> only chan_reset_n[0] and [2] release, 4 cycles apart; cal_success=6'b000101 is sufficient to reach RUN; chan_reset_n[1,3,4,5] stay 0.
3. Fail and retry. CAL_TIMEOUT=32, MAX_RETRY=2; cal_fail[3] pulsed in CAL_WAIT on attempts 1 and 2, third attempt passes -> retry_cnt=2, chan resets reasserted each retry, RUN reached; simultaneous cal_success=3F and cal_fail[0]=1 counts as a fail.
4. Timeout to ERROR. cal_success held 0 -> after 3 timeouts of 32 cycles, seq_state=5, error=1, leds[6]=1, kernel_reset_n=0; holding further has no effect.
5. nPOR mid-operation. Drop pcie_npor for 1 cycle while in RUN -> 3 cycles later all resets=0, seq_state=0, retry_cnt=0; full sequence then repeats; an nPOR drop in ERROR recovers the same way.
6. Calibration loss. With BOARD_RESET_HEARTBEAT_EN and HEARTBEAT_BITS=4, drop cal_success[1] in RUN -> ERROR next cycle, leds[7] toggles every 2 cycles; in RUN, leds[7] toggles every 8 cycles.
